// File: rtl/disp_mux_ctrl.sv
// -----------------------------------------------------------------------------
// disp_mux_ctrl
//
// Time-multiplexing controller for a dual common-anode 7-segment display.
// It holds two hex digits and shows them one at a time on hex_out, which feeds
// the hex-to-segment decoder. Each digit slot ends with a short interval in
// which both anodes are off, so the old segment pattern cannot ghost onto the
// next digit. New digit pairs are committed only at frame boundaries, so a
// digit never changes while it is being displayed.
//
// Slot sequence: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0 ...
//   SHOW0/SHOW1   : CYCLES_PER_DIGIT-BLANK_CYCLES cycles each
//   BLANK0/BLANK1 : BLANK_CYCLES cycles each
//   Frame period  : 2*CYCLES_PER_DIGIT cycles
//
// Parameters:
//   CYCLES_PER_DIGIT : clk cycles per digit slot, blank included
//   BLANK_CYCLES     : cycles at the end of each slot with both anodes off
//                      (1 .. CYCLES_PER_DIGIT-1)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   digit0[3:0]  in   right digit value, sampled when load is high
//   digit1[3:0]  in   left digit value, sampled when load is high
//   load         in   single-cycle strobe requesting a new digit pair
//   hex_out[3:0] out  nibble to the segment decoder
//   an0_n        out  right-digit anode enable, active low
//   an1_n        out  left-digit anode enable, active low
//   frame_start  out  one-cycle pulse on the first cycle of SHOW0
//   load_pending out  high while a loaded pair is waiting for commit
//
// Optional build macro:
//   DISP_LEAD_ZERO_BLANK_EN : when defined, a left digit of 0 is suppressed
//                             (an1_n stays high through SHOW1). Slot timing
//                             and hex_out are unaffected.
// -----------------------------------------------------------------------------
module disp_mux_ctrl #(
   parameter int CYCLES_PER_DIGIT = 24000,
   parameter int BLANK_CYCLES     = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic       load,
   output logic [3:0] hex_out,
   output logic       an0_n,
   output logic       an1_n,
   output logic       frame_start,
   output logic       load_pending
);

   localparam int CW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;

   // Terminal counts: the counter runs 0 .. duration-1 inside each state.
   localparam logic [CW-1:0] SHOW_LAST  = CW'(CYCLES_PER_DIGIT - BLANK_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      SHOW0  = 2'd0,
      BLANK0 = 2'd1,
      SHOW1  = 2'd2,
      BLANK1 = 2'd3
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [CW-1:0]   cnt_reg;
   logic            slot_end;
   logic            commit;
   logic [3:0]      pend0_reg;
   logic [3:0]      pend1_reg;
   logic [3:0]      shown0_reg;
   logic [3:0]      shown1_reg;
   logic [3:0]      shown0_next;
   logic [3:0]      shown1_next;
   logic [3:0]      hex_next;
   logic            an1_on_next;

   // Slot sequencing and the pair that will be displayed after this edge.
   always_comb begin
      state_next  = state_reg;
      shown0_next = shown0_reg;
      shown1_next = shown1_reg;

      if ((state_reg == SHOW0) || (state_reg == SHOW1))
         slot_end = (cnt_reg == SHOW_LAST);
      else
         slot_end = (cnt_reg == BLANK_LAST);

      if (slot_end) begin
         case (state_reg)
            SHOW0:   state_next = BLANK0;
            BLANK0:  state_next = SHOW1;
            SHOW1:   state_next = BLANK1;
            BLANK1:  state_next = SHOW0;
            default: state_next = BLANK1;
         endcase
      end

      // Frame boundary: a load arriving on this very edge bypasses the
      // pending registers and takes effect in the frame that starts now.
      commit = slot_end && (state_reg == BLANK1);
      if (commit) begin
         if (load) begin
            shown0_next = digit0;
            shown1_next = digit1;
         end else if (load_pending) begin
            shown0_next = pend0_reg;
            shown1_next = pend1_reg;
         end
      end

      // hex_out leads its anode: the blank before each show slot already
      // carries the upcoming digit.
      if ((state_next == SHOW0) || (state_next == BLANK1))
         hex_next = shown0_next;
      else
         hex_next = shown1_next;

`ifdef DISP_LEAD_ZERO_BLANK_EN
      an1_on_next = (state_next == SHOW1) && (shown1_next != 4'd0);
`else
      an1_on_next = (state_next == SHOW1);
`endif
   end

   // State, counter, digit registers and the registered Moore outputs, which
   // are decoded from the next state so they line up with state_reg.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= BLANK1;
         cnt_reg      <= '0;
         pend0_reg    <= 4'd0;
         pend1_reg    <= 4'd0;
         shown0_reg   <= 4'd0;
         shown1_reg   <= 4'd0;
         load_pending <= 1'b0;
         hex_out      <= 4'd0;
         an0_n        <= 1'b1;
         an1_n        <= 1'b1;
         frame_start  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= slot_end ? '0 : cnt_reg + CW'(1);
         shown0_reg <= shown0_next;
         shown1_reg <= shown1_next;

         if (load) begin
            pend0_reg <= digit0;
            pend1_reg <= digit1;
         end

         if (commit)
            load_pending <= 1'b0;
         else if (load)
            load_pending <= 1'b1;

         hex_out     <= hex_next;
         an0_n       <= ~(state_next == SHOW0);
         an1_n       <= ~an1_on_next;
         frame_start <= commit;
      end
   end

endmodule
